multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle MIPS datapath; sits directly upstream of the ALU controller and drives its 2-bit `aluop` input together with all datapath mux selects and write strobes. It sequences each instruction through fetch, decode, execute, memory and writeback, and stalls on memory using a ready handshake. Supported opcodes are lb, sb, R-type, beq, addi and j.

## Interface
- No parameters.
- `clk_i` input 1: clock; all state updates on rising edge.
- `rst_n_i` input 1: asynchronous, active-low reset.
- `op_i` input 6: opcode field from the instruction register.
- `zero_i` input 1: ALU zero flag.
- `mem_ready_i` input 1: memory has completed the current read or write this cycle.
- `pcen_o` output 1: PC write enable.
- `irwrite_o` output 1: instruction register write enable.
- `memwrite_o` output 1: memory write request.
- `regwrite_o` output 1: register file write enable.
- `iord_o` output 1: memory address select (0 = PC, 1 = ALUOut).
- `regdst_o` output 1: destination register select (1 = rd, 0 = rt).
- `memtoreg_o` output 1: writeback data select (1 = memory data).
- `alusrca_o` output 1: ALU A select (0 = PC, 1 = register A).
- `alusrcb_o` output 2: ALU B select (00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2).
- `pcsrc_o` output 2: next PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
- `aluop_o` output 2: to the ALU controller (00 = add, 01 = sub, 10 = decode funct).
- `illegal_o` output 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state_o` output 4: current state encoding, for debug.

## Operation
- Opcodes: lb 100000, sb 101000, R-type 000000, beq 000100, addi 001000, j 000010.
- State register is 4 bits. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- Outputs are decoded combinationally from the state, plus `mem_ready_i`/`zero_i` where noted. Any output not listed for a state is 0.
- `pcen_o` = pcwrite | (branch & `zero_i`).
- FETCH: alusrcb=01.
  - irwrite = pcwrite = `mem_ready_i`.
  - Next state is DECODE if `mem_ready_i`, else stay in FETCH.
- DECODE: alusrcb=11, which computes the branch target.
  - Next state by opcode: lb/sb → MEMADR, R → RTYPEEX, beq → BEQEX, addi → ADDIEX, j → JEX.
  - Any other opcode → FETCH, with `illegal_o`=1.
- MEMADR: alusrca=1, alusrcb=10. Next state is MEMRD for lb, MEMWR for sb.
- MEMRD: iord=1. Next state is MEMWB if `mem_ready_i`, else hold.
- MEMWB: memtoreg=1, regwrite=1. Next state is FETCH.
- MEMWR: iord=1, memwrite=1.
  - memwrite stays high until ready.
  - Next state is FETCH if `mem_ready_i`, else hold.
- RTYPEEX: alusrca=1, aluop=10. Next state is RTYPEWB.
- RTYPEWB: regdst=1, regwrite=1. Next state is FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1. Next state is FETCH.
- ADDIEX: alusrca=1, alusrcb=10. Next state is ADDIWB.
- ADDIWB: regwrite=1. Next state is FETCH.
- JEX: pcsrc=10, pcwrite=1. Next state is FETCH.
- An unreachable state encoding (12–15) → FETCH on the next edge, with all outputs 0.

## Timing
- Reset: `rst_n_i` low forces state to FETCH immediately (asynchronous).
  - While reset is held, `pcen_o`, `irwrite_o`, `memwrite_o`, `regwrite_o` and `illegal_o` are forced 0.
  - Other outputs take their FETCH values: alusrcb=01, all others 0. `state_o`=0.
- First edge after reset deassertion: normal FETCH behaviour.
- Reset asserted mid-instruction abandons the instruction; no further write strobe is issued.
- Cycles per instruction with `mem_ready_i` constantly 1: lb 5, sb 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle `mem_ready_i` is low in FETCH/MEMRD/MEMWR adds one cycle.
- `op_i` is sampled in DECODE and MEMADR. The datapath holds the IR stable, since irwrite is only high in FETCH.
- `zero_i` is used combinationally in BEQEX only.

## Test plan
- Reset → `state_o`=0, all strobes 0 while `rst_n_i`=0, alusrcb=01. Release with ready=1 → `pcen_o`=`irwrite_o`=1 in the first cycle.
- R-type (op 000000), ready=1 → states 0,1,6,7,0. `aluop_o`=10 in state 6; regwrite=1 and regdst=1 in state 7.
- lb with ready low for 2 cycles in FETCH and 3 cycles in MEMRD → states 0,0,0,1,2,3,3,3,3,4,0. `iord_o`=1 throughout MEMRD; memtoreg=1 and regwrite=1 in state 4.
- sb with ready low for 1 cycle in MEMWR → `memwrite_o`=1 for 2 consecutive cycles, then state 0.
- beq in BEQEX: `zero_i`=1 → `pcen_o`=1, pcsrc=01, aluop=01. `zero_i`=0 → `pcen_o`=0.
- Illegal opcode 111111 → `illegal_o`=1 for one cycle in DECODE, then FETCH. Reset asserted in RTYPEEX → state 0 immediately, `regwrite_o` never asserted.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// It sequences fetch/decode/execute/memory/writeback and stalls on the memory ready handshake.
//
// state   | meaning
// --------+----------------------------------------------
// FETCH   | read instruction at PC, PC += 4 on ready
// DECODE  | register read, branch target into ALUOut
// MEMADR  | effective address = A + signext imm
// MEMRD   | load read at ALUOut, hold until ready
// MEMWB   | write loaded data to rt
// MEMWR   | store write at ALUOut, hold until ready
// RTYPEEX | ALU op from funct
// RTYPEWB | write ALU result to rd
// BEQEX   | compare A - B, branch on zero
// ADDIEX  | A + signext imm
// ADDIWB  | write ALU result to rt
// JEX     | PC = jump target
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pcen_o,
    output logic       irwrite_o,
    output logic       memwrite_o,
    output logic       regwrite_o,
    output logic       iord_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] pcsrc_o,
    output logic [1:0] aluop_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    state_t state_q, state_d;

    logic pcwrite, branch, irwrite, memwrite, regwrite, illegal;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        illegal    = 1'b0;
        iord_o     = 1'b0;
        regdst_o   = 1'b0;
        memtoreg_o = 1'b0;
        alusrca_o  = 1'b0;
        alusrcb_o  = 2'b00;
        pcsrc_o    = 2'b00;
        aluop_o    = 2'b00;

        case (state_q)
            FETCH: begin
                alusrcb_o = 2'b01;
                irwrite   = mem_ready_i;
                pcwrite   = mem_ready_i;
                state_d   = mem_ready_i ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb_o = 2'b11;
                case (op_i)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_R:         state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                state_d   = (op_i == OP_SB) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord_o  = 1'b1;
                state_d = mem_ready_i ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg_o = 1'b1;
                regwrite   = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord_o   = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_ready_i ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca_o = 1'b1;
                aluop_o   = 2'b10;
                state_d   = RTYPEWB;
            end
            RTYPEWB: begin
                regdst_o = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BEQEX: begin
                alusrca_o = 1'b1;
                aluop_o   = 2'b01;
                pcsrc_o   = 2'b01;
                branch    = 1'b1;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsrc_o = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing writes while reset is held.
    assign pcen_o     = rst_n_i & (pcwrite | (branch & zero_i));
    assign irwrite_o  = rst_n_i & irwrite;
    assign memwrite_o = rst_n_i & memwrite;
    assign regwrite_o = rst_n_i & regwrite;
    assign illegal_o  = rst_n_i & illegal;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed vector bench for multicycle_ctrl: a per-cycle table plus reset corner sequences.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       zero;
    logic       ready;
    logic       pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .op_i        (op),
        .zero_i      (zero),
        .mem_ready_i (ready),
        .pcen_o      (pcen),
        .irwrite_o   (irwrite),
        .memwrite_o  (memwrite),
        .regwrite_o  (regwrite),
        .iord_o      (iord),
        .regdst_o    (regdst),
        .memtoreg_o  (memtoreg),
        .alusrca_o   (alusrca),
        .alusrcb_o   (alusrcb),
        .pcsrc_o     (pcsrc),
        .aluop_o     (aluop),
        .illegal_o   (illegal),
        .state_o     (state)
    );

    // {pcen irwrite memwrite regwrite}_{iord regdst memtoreg alusrca}_alusrcb_pcsrc_aluop_illegal
    logic [14:0] outs;
    assign outs = {pcen, irwrite, memwrite, regwrite, iord, regdst, memtoreg, alusrca,
                   alusrcb, pcsrc, aluop, illegal};

    localparam logic [14:0] O_FETCH_R = 15'b1100_0000_01_00_00_0;
    localparam logic [14:0] O_FETCH_W = 15'b0000_0000_01_00_00_0;
    localparam logic [14:0] O_DEC     = 15'b0000_0000_11_00_00_0;
    localparam logic [14:0] O_DEC_ILL = 15'b0000_0000_11_00_00_1;
    localparam logic [14:0] O_MEMADR  = 15'b0000_0001_10_00_00_0;
    localparam logic [14:0] O_MEMRD   = 15'b0000_1000_00_00_00_0;
    localparam logic [14:0] O_MEMWB   = 15'b0001_0010_00_00_00_0;
    localparam logic [14:0] O_MEMWR   = 15'b0010_1000_00_00_00_0;
    localparam logic [14:0] O_RTEX    = 15'b0000_0001_00_00_10_0;
    localparam logic [14:0] O_RTWB    = 15'b0001_0100_00_00_00_0;
    localparam logic [14:0] O_BEQ_T   = 15'b1000_0001_00_01_01_0;
    localparam logic [14:0] O_BEQ_N   = 15'b0000_0001_00_01_01_0;
    localparam logic [14:0] O_ADDIEX  = 15'b0000_0001_10_00_00_0;
    localparam logic [14:0] O_ADDIWB  = 15'b0001_0000_00_00_00_0;
    localparam logic [14:0] O_JEX     = 15'b1000_0000_00_10_00_0;

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic        ready;
        logic [3:0]  st;
        logic [14:0] out;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] o, input logic z, input logic r,
                       input logic [3:0] s, input logic [14:0] e);
        vec_t v;
        v.op = o; v.zero = z; v.ready = r; v.st = s; v.out = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, check state/outputs, then advance one clock.
    task automatic apply(input vec_t v, input int idx);
        op = v.op; zero = v.zero; ready = v.ready;
        #1;
        check($sformatf("vec%0d state", idx), {11'd0, state}, {11'd0, v.st});
        check($sformatf("vec%0d outs", idx), outs, v.out);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t hv;

        // R-type
        add(6'b000000, 0, 1, 4'd0,  O_FETCH_R);
        add(6'b000000, 0, 1, 4'd1,  O_DEC);
        add(6'b000000, 0, 1, 4'd6,  O_RTEX);
        add(6'b000000, 0, 1, 4'd7,  O_RTWB);
        // lb: 2 stall cycles in FETCH, 3 in MEMRD
        add(6'b100000, 0, 0, 4'd0,  O_FETCH_W);
        add(6'b100000, 0, 0, 4'd0,  O_FETCH_W);
        add(6'b100000, 0, 1, 4'd0,  O_FETCH_R);
        add(6'b100000, 0, 1, 4'd1,  O_DEC);
        add(6'b100000, 0, 1, 4'd2,  O_MEMADR);
        add(6'b100000, 0, 0, 4'd3,  O_MEMRD);
        add(6'b100000, 0, 0, 4'd3,  O_MEMRD);
        add(6'b100000, 0, 0, 4'd3,  O_MEMRD);
        add(6'b100000, 0, 1, 4'd3,  O_MEMRD);
        add(6'b100000, 0, 1, 4'd4,  O_MEMWB);
        // sb: 1 stall cycle in MEMWR
        add(6'b101000, 0, 1, 4'd0,  O_FETCH_R);
        add(6'b101000, 0, 1, 4'd1,  O_DEC);
        add(6'b101000, 0, 1, 4'd2,  O_MEMADR);
        add(6'b101000, 0, 0, 4'd5,  O_MEMWR);
        add(6'b101000, 0, 1, 4'd5,  O_MEMWR);
        // beq taken, then not taken
        add(6'b000100, 0, 1, 4'd0,  O_FETCH_R);
        add(6'b000100, 0, 1, 4'd1,  O_DEC);
        add(6'b000100, 1, 1, 4'd8,  O_BEQ_T);
        add(6'b000100, 1, 1, 4'd0,  O_FETCH_R);
        add(6'b000100, 1, 1, 4'd1,  O_DEC);
        add(6'b000100, 0, 1, 4'd8,  O_BEQ_N);
        // addi with zero high: branch must not leak into pcen
        add(6'b001000, 1, 1, 4'd0,  O_FETCH_R);
        add(6'b001000, 1, 1, 4'd1,  O_DEC);
        add(6'b001000, 1, 1, 4'd9,  O_ADDIEX);
        add(6'b001000, 1, 1, 4'd10, O_ADDIWB);
        // j
        add(6'b000010, 0, 1, 4'd0,  O_FETCH_R);
        add(6'b000010, 0, 1, 4'd1,  O_DEC);
        add(6'b000010, 0, 1, 4'd11, O_JEX);
        // illegal opcode, then a clean fetch
        add(6'b111111, 0, 1, 4'd0,  O_FETCH_R);
        add(6'b111111, 0, 1, 4'd1,  O_DEC_ILL);
        add(6'b111111, 0, 1, 4'd0,  O_FETCH_R);
        add(6'b000000, 0, 1, 4'd1,  O_DEC);
        add(6'b000000, 0, 1, 4'd6,  O_RTEX);
        add(6'b000000, 0, 1, 4'd7,  O_RTWB);

        // Reset held with ready high: strobes forced off, FETCH muxes
        rst_n = 1'b0; op = 6'd0; zero = 1'b0; ready = 1'b1;
        #1;
        check("reset state", {11'd0, state}, 15'd0);
        check("reset outs", outs, O_FETCH_W);
        @(posedge clk);
        @(negedge clk);
        check("reset held state", {11'd0, state}, 15'd0);
        check("reset held outs", outs, O_FETCH_W);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset asserted in RTYPEEX abandons the instruction without a write
        hv.op = 6'b000000; hv.zero = 1'b0; hv.ready = 1'b1;
        hv.st = 4'd0; hv.out = O_FETCH_R; apply(hv, 100);
        hv.st = 4'd1; hv.out = O_DEC;     apply(hv, 101);
        #1;
        check("pre-reset rtypeex", {11'd0, state}, 15'd6);
        rst_n = 1'b0;
        #1;
        check("async reset state", {11'd0, state}, 15'd0);
        check("async reset outs", outs, O_FETCH_W);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("no regwrite %0d", c), {14'd0, regwrite}, 15'd0);
            check($sformatf("held state %0d", c), {11'd0, state}, 15'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hv.st = 4'd0; hv.out = O_FETCH_R; apply(hv, 102);
        hv.st = 4'd1; hv.out = O_DEC;     apply(hv, 103);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
